// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin sequencer in front of the single-ported
// main memory. Port 0 is the instruction cache and port 1 is the data cache.
// Each access rises mem_enable, waits for mem_complete or a timeout, and
// returns a one-cycle done pulse with read data to the granted port.
module mem_arbiter #(
  parameter int ADDR_LENGTH = 9,
  parameter int BLOCK_SIZE  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [ADDR_LENGTH-1:0] addr0,
  input  logic [ADDR_LENGTH-1:0] addr1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [BLOCK_SIZE-1:0]  wdata0,
  input  logic [BLOCK_SIZE-1:0]  wdata1,
  output logic                   done0,
  output logic                   done1,
  output logic [BLOCK_SIZE-1:0]  rdata,
  output logic                   err,
  output logic                   mem_enable,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [BLOCK_SIZE-1:0]  mem_data_in,
  input  logic [BLOCK_SIZE-1:0]  mem_data_out,
  input  logic                   mem_complete
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } arbState_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  arbState_e               state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    lastGrant_q, lastGrant_d;
  logic [7:0]              timer_q, timer_d;
  logic [ADDR_LENGTH-1:0]  memAddr_q, memAddr_d;
  logic                    memWe_q, memWe_d;
  logic [BLOCK_SIZE-1:0]   memDataIn_q, memDataIn_d;
  logic                    memEnable_q, memEnable_d;
  logic [BLOCK_SIZE-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    done0_q, done0_d;
  logic                    done1_q, done1_d;
  logic                    pickPort;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign pickPort = (req0 && req1) ? ~lastGrant_q : req1;

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      timer_q     <= 8'd0;
      memAddr_q   <= '0;
      memWe_q     <= 1'b0;
      memDataIn_q <= '0;
      memEnable_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      timer_q     <= timer_d;
      memAddr_q   <= memAddr_d;
      memWe_q     <= memWe_d;
      memDataIn_q <= memDataIn_d;
      memEnable_q <= memEnable_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
    end
  end

  // Next-state: one access at a time, with a forced low cycle after DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_complete || (timer_q == TimeoutVal)) state_d = DONE;
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from current and next state.
  always_comb begin
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    timer_d     = timer_q;
    memAddr_d   = memAddr_q;
    memWe_d     = memWe_q;
    memDataIn_d = memDataIn_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    memEnable_d = (state_d == ISSUE) || (state_d == WAIT);
    done0_d     = (state_d == DONE) && !grant_q;
    done1_d     = (state_d == DONE) && grant_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d     = pickPort;
          memAddr_d   = pickPort ? addr1  : addr0;
          memWe_d     = pickPort ? we1    : we0;
          memDataIn_d = pickPort ? wdata1 : wdata0;
        end
      end
      ISSUE: timer_d = 8'd0;
      WAIT: begin
        timer_d = timer_q + 8'd1;
        if (mem_complete) begin
          rdata_d = mem_data_out;
          err_d   = 1'b0;
        end else if (timer_q == TimeoutVal) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE:    lastGrant_d = grant_q;
      default: ;
    endcase
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign mem_enable  = memEnable_q;
  assign mem_addr    = memAddr_q;
  assign mem_we      = memWe_q;
  assign mem_data_in = memDataIn_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural memory (DELAY=5, mem[i]=i) with an
// optional stuck mode, directed scenarios, then two randomized requesters.
// Expected read data comes from a serial reference memory updated at each done.
module tb_mem_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int TO = 20;
   localparam int DELAY = 5;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic          we0 = 1'b0, we1 = 1'b0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          done0, done1, err;
   logic [DW-1:0] rdata;
   logic          mem_enable, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out = '0;
   logic          mem_complete = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;
   int done0Count = 0;
   int done1Count = 0;
   int enRises = 0;
   bit stuckMode = 1'b0;

   logic [DW-1:0] memArr [0:(1<<AW)-1];
   logic [DW-1:0] refMem [0:(1<<AW)-1];

   // Free-running clock
   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_LENGTH(AW), .BLOCK_SIZE(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rdata(rdata), .err(err),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_complete(mem_complete)
   );

   // Behavioural memory: a rising enable starts an access that completes
   // DELAY cycles later, returning old contents; stuck mode never completes
   logic          enPrev = 1'b0;
   logic          busy = 1'b0;
   int            cnt = 0;
   logic [AW-1:0] lAddr = '0;
   logic          lWe = 1'b0;
   logic [DW-1:0] lData = '0;
   always @(posedge clk) begin
      enPrev <= mem_enable;
      if (!mem_enable) begin
         busy <= 1'b0;
         mem_complete <= 1'b0;
      end else if (!enPrev) begin
         busy <= 1'b1;
         cnt <= DELAY;
         lAddr <= mem_addr;
         lWe <= mem_we;
         lData <= mem_data_in;
         enRises <= enRises + 1;
      end else if (busy) begin
         if (cnt > 1) begin
            cnt <= cnt - 1;
         end else begin
            busy <= 1'b0;
            if (!stuckMode) begin
               mem_complete <= 1'b1;
               mem_data_out <= memArr[lAddr];
               if (lWe) memArr[lAddr] <= lData;
            end
         end
      end
   end

   // Count completion pulses per port for the fairness bound
   always @(posedge clk) begin
      if (done0) done0Count++;
      if (done1) done1Count++;
   end

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Done pulses must be exclusive and exactly one cycle long
   logic prevDone0 = 1'b0, prevDone1 = 1'b0;
   always @(negedge clk) begin
      if (done0 || done1) checkOutput("doneExclusive", 32'(done0 & done1), 32'd0);
      if (done0) checkOutput("pulse0", 32'(prevDone0), 32'd0);
      if (done1) checkOutput("pulse1", 32'(prevDone1), 32'd0);
      prevDone0 = done0;
      prevDone1 = done1;
   end

   // One transaction on one port; cycles counts the raise cycle as 1.
   // changeAt alters the port's address mid-flight to prove it is latched.
   task automatic applyStimulus(input int port, input logic [AW-1:0] addr,
                                input logic we, input logic [DW-1:0] wdata,
                                input int changeAt, input bit expectErr,
                                output int cycles);
      bit got;
      int otherStart;
      logic [DW-1:0] expData;
      otherStart = (port == 1) ? done0Count : done1Count;
      if (port == 1) begin
         addr1 = addr; we1 = we; wdata1 = wdata; req1 = 1'b1;
      end else begin
         addr0 = addr; we0 = we; wdata0 = wdata; req0 = 1'b1;
      end
      cycles = 1;
      got = 1'b0;
      while (!got && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (cycles == changeAt) begin
            if (port == 1) addr1 = addr + AW'(10);
            else addr0 = addr + AW'(10);
         end
         got = (port == 1) ? done1 : done0;
      end
      if (!got) begin
         checkOutput($sformatf("doneTimeout%0d", port), 32'd0, 32'd1);
      end else begin
         expData = expectErr ? '0 : refMem[addr];
         checkOutput($sformatf("rdata%0d", port), rdata, expData);
         checkOutput($sformatf("err%0d", port), 32'(err), 32'(expectErr));
         if (we && !expectErr) refMem[addr] = wdata;
         checkOutput($sformatf("starve%0d", port),
                     32'((((port == 1) ? done0Count : done1Count) - otherStart) <= 1), 32'd1);
      end
      if (port == 1) req1 = 1'b0;
      else req0 = 1'b0;
   endtask

   // Hard stop in case something wedges outside a bounded wait
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by randomized two-port traffic
   initial begin
      int cyc, e0, d1, n, d1Before;
      int order [4];
      logic [DW-1:0] got [4];

      for (int i = 0; i < (1 << AW); i++) begin
         memArr[i] = DW'(i);
         refMem[i] = DW'(i);
      end

      // Reset state
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstCtrl", 32'({done0, done1, err, mem_enable, mem_we}), 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstAddr", 32'(mem_addr), 32'd0);
      checkOutput("rstDataIn", mem_data_in, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single read on port 0, one enable rise, port 1 silent
      e0 = enRises;
      d1 = done1Count;
      applyStimulus(0, 10, 1'b0, '0, -1, 1'b0, cyc);
      checkOutput("latency", 32'(cyc), 32'd9);
      repeat (3) @(negedge clk);
      checkOutput("enRises", 32'(enRises - e0), 32'd1);
      checkOutput("noDone1", 32'(done1Count - d1), 32'd0);

      // Write returns old contents, then the read sees the new word
      applyStimulus(1, 50, 1'b1, 32'hABCD, -1, 1'b0, cyc);
      applyStimulus(1, 50, 1'b0, '0, -1, 1'b0, cyc);
      checkOutput("readBack", refMem[50], 32'hABCD);

      // Address change during WAIT is ignored
      repeat (2) @(negedge clk);
      applyStimulus(0, 10, 1'b0, '0, 5, 1'b0, cyc);

      // Both ports held high from reset alternate 0,1,0,1
      reset_n = 1'b0;
      addr0 = 3; we0 = 1'b0; req0 = 1'b1;
      addr1 = 7; we1 = 1'b0; req1 = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && n < 4; c++) begin
         @(negedge clk);
         if (done0 || done1) begin
            order[n] = done1 ? 1 : 0;
            got[n] = rdata;
            n++;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checkOutput("altCount", 32'(n), 32'd4);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("altOrder%0d", i), 32'(order[i]), 32'(i % 2));
         checkOutput($sformatf("altData%0d", i), got[i], refMem[(i % 2 == 1) ? 7 : 3]);
      end

      // Reset during WAIT of a port-1 read aborts without a done pulse
      repeat (3) @(negedge clk);
      d1Before = done1Count;
      addr1 = 30; we1 = 1'b0; req1 = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("midEnable", 32'(mem_enable), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("abortEnable", 32'(mem_enable), 32'd0);
      req1 = 1'b0;
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abortNoDone", 32'(done1Count - d1Before), 32'd0);
      applyStimulus(0, 4, 1'b0, '0, -1, 1'b0, cyc);

      // Memory never completes: timeout with err, then normal service
      stuckMode = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(0, 12, 1'b0, '0, -1, 1'b1, cyc);
      checkOutput("timeoutLatency", 32'(cyc), 32'd24);
      stuckMode = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(0, 12, 1'b0, '0, -1, 1'b0, cyc);

      // Randomized traffic from both requesters
      repeat (3) @(negedge clk);
      fork
         begin
            int c0;
            for (int i = 0; i < 15; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               applyStimulus(0, AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                             DW'($urandom), -1, 1'b0, c0);
            end
         end
         begin
            int c1;
            for (int i = 0; i < 15; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               applyStimulus(1, AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                             DW'($urandom), -1, 1'b0, c1);
            end
         end
      join

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
